// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs a valid/ready byte stream, little-endian, into BYTES_PER_WORD-byte
//   words presented on a registered valid/ready output. One byte per cycle,
//   no bubbles while the consumer is ready.
//
// Optional feature macro: PACKER_FLUSH_EN
//   When defined, adds the flush input and the out_be byte-enable output so a
//   partially filled word can be emitted on request.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : input byte valid
//   in_ready   : byte accepted this cycle (combinational on out_ready)
//   in_data    : input byte [BYTE_W-1:0]
//   out_valid  : out_data holds a packed word
//   out_ready  : consumer accepts the word
//   out_data   : packed word, byte k at [k*BYTE_W +: BYTE_W]
//   flush      : (PACKER_FLUSH_EN) single-cycle request to emit a partial word
//   out_be     : (PACKER_FLUSH_EN) valid-byte mask for out_data

module byte_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int BYTE_W         = 8,
  localparam int WORD_W        = BYTES_PER_WORD * BYTE_W,
  localparam int CNT_W         = $clog2(BYTES_PER_WORD)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                      flush,
  output logic [BYTES_PER_WORD-1:0] out_be
`endif
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;
  logic [WORD_W-1:0] acc_merged;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              out_valid_nxt;
  logic              load;
  logic              slot_free;
  logic              last_slot;
  logic              accept;

`ifdef PACKER_FLUSH_EN
  logic                      flush_pending;
  logic                      flush_pending_nxt;
  logic [BYTES_PER_WORD-1:0] load_be;
  logic [31:0]               fill;
`endif

  always_comb begin
    slot_free = !out_valid || out_ready;
    last_slot = (cnt == LAST_SLOT);
`ifdef PACKER_FLUSH_EN
    in_ready  = !flush_pending && (!last_slot || slot_free);
`else
    in_ready  = !last_slot || slot_free;
`endif
    accept    = in_valid && in_ready;

    // Accumulator view including this cycle's byte; unfilled slots are zero
    // because acc is cleared on every emission.
    acc_merged = acc;
    if (accept) begin
      acc_merged[cnt*BYTE_W +: BYTE_W] = in_data;
    end

    cnt_nxt       = cnt;
    acc_nxt       = acc_merged;
    load          = 1'b0;
    out_valid_nxt = out_valid && !out_ready;

    if (accept) begin
      cnt_nxt = last_slot ? '0 : cnt + CNT_W'(1);
    end

`ifdef PACKER_FLUSH_EN
    flush_pending_nxt = flush_pending;
    load_be           = '1;
    fill              = 32'(cnt) + 32'(accept);
`endif

    if (accept && last_slot) begin
      load    = 1'b1;
      acc_nxt = '0;
    end
`ifdef PACKER_FLUSH_EN
    else if (flush_pending || (flush && (fill != 32'd0))) begin
      // A partial word waits here (with input blocked) until the output
      // register frees up.
      if (slot_free) begin
        load              = 1'b1;
        acc_nxt           = '0;
        cnt_nxt           = '0;
        flush_pending_nxt = 1'b0;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
          load_be[k] = (k < fill);
        end
      end else begin
        flush_pending_nxt = 1'b1;
      end
    end
`endif

    if (load) begin
      out_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef PACKER_FLUSH_EN
      out_be        <= '0;
      flush_pending <= 1'b0;
`endif
    end else begin
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      out_valid <= out_valid_nxt;
      if (load) begin
        out_data <= acc_merged;
`ifdef PACKER_FLUSH_EN
        out_be   <= load_be;
`endif
      end
`ifdef PACKER_FLUSH_EN
      flush_pending <= flush_pending_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

  localparam int BPW = 4;
  localparam int BW  = 8;
  localparam int WW  = BPW * BW;
`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
`ifdef PACKER_FLUSH_EN
  logic           flush;
  logic [BPW-1:0] out_be;
`endif

  always #5 clk = ~clk;

  byte_word_packer #(
    .BYTES_PER_WORD(BPW),
    .BYTE_W        (BW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PACKER_FLUSH_EN
    ,
    .flush    (flush),
    .out_be   (out_be)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending bytes in a queue, a single output slot.
  logic [BW-1:0]  part[$];
  bit             mv;
  logic [WW-1:0]  mdata;
  logic [BPW-1:0] mbe;
  bit             fpend;
  logic           last_rdy;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    mv    = 1'b0;
    mdata = '0;
    mbe   = '0;
    fpend = 1'b0;
  endtask

  task automatic model_emit(input logic [BPW-1:0] be);
    logic [WW-1:0] w;
    w = '0;
    foreach (part[i]) w[i*BW +: BW] = part[i];
    mdata = w;
    mbe   = be;
    mv    = 1'b1;
    part.delete();
  endtask

  // One clock of stimulus: drive after the falling edge, check in_ready
  // before the rising edge, check outputs just after it.
  task automatic step(input bit v, input logic [BW-1:0] d, input bit ordy, input bit fl);
    bit rdy, acc, sfree;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
`ifdef PACKER_FLUSH_EN
    flush     = fl;
`endif
    #1;
    sfree = !mv || ordy;
    rdy   = !fpend && ((part.size() != BPW - 1) || sfree);
    acc   = v && rdy;
    last_rdy = in_ready;
    check("in_ready", WW'(in_ready), WW'(rdy));
    @(posedge clk);
    if (acc) part.push_back(d);
    if (mv && ordy) mv = 1'b0;
    if (part.size() == BPW) begin
      model_emit('1);
    end else if (FLUSH_EN && (fpend || (fl && part.size() > 0))) begin
      if (sfree) begin
        model_emit(BPW'((1 << part.size()) - 1));
        fpend = 1'b0;
      end else begin
        fpend = 1'b1;
      end
    end
    #1;
    check("out_valid", WW'(out_valid), WW'(mv));
    if (mv) begin
      check("out_data", out_data, mdata);
`ifdef PACKER_FLUSH_EN
      check("out_be", WW'(out_be), WW'(mbe));
`endif
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
    model_reset();
    #12;
    check("rst_out_valid", WW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", WW'(in_ready), WW'(1));
    reset_n = 1'b1;

    // Streaming with consumer always ready
    step(1, 8'h11, 1, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h33, 1, 0);
    step(1, 8'h44, 1, 0);
    check("stream_w0", out_data, 32'h44332211);
    step(1, 8'h55, 1, 0);
    step(1, 8'h66, 1, 0);
    step(1, 8'h77, 1, 0);
    step(1, 8'h88, 1, 0);
    check("stream_w1", out_data, 32'h88776655);
    step(0, 8'h00, 1, 0);

    // Backpressure on the final byte
    step(1, 8'h11, 1, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h33, 1, 0);
    step(1, 8'h44, 0, 0);
    step(1, 8'h55, 0, 0);
    step(1, 8'h66, 0, 0);
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 0, 0);
    check("bp_ready_low", WW'(last_rdy), '0);
    check("bp_hold", out_data, 32'h44332211);
    step(1, 8'h88, 0, 0);
    check("bp_hold2", out_data, 32'h44332211);
    step(1, 8'h88, 1, 0);
    check("bp_release", out_data, 32'h88776655);

    // Consume and reload in the same cycle
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 1, 0);
    check("b2b_valid", WW'(out_valid), WW'(1));
    check("b2b_data", out_data, 32'h04030201);
    step(0, 8'h00, 1, 0);

    // Asynchronous reset mid-word
    step(1, 8'hE1, 1, 0);
    step(1, 8'hE2, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", WW'(out_valid), '0);
    check("mid_rst_ready", WW'(in_ready), WW'(1));
    #4 reset_n = 1'b1;
    step(1, 8'hA1, 1, 0);
    step(1, 8'hB2, 1, 0);
    step(1, 8'hC3, 1, 0);
    step(1, 8'hD4, 1, 0);
    check("post_rst_word", out_data, 32'hD4C3B2A1);
    step(0, 8'h00, 1, 0);

`ifdef PACKER_FLUSH_EN
    // Partial word flush, output free
    step(1, 8'hAA, 1, 0);
    step(1, 8'hBB, 1, 0);
    step(0, 8'h00, 1, 1);
    check("flush_data", out_data, 32'h0000BBAA);
    check("flush_be", WW'(out_be), WW'(4'b0011));
    // Flush while output stalled
    step(1, 8'hCC, 0, 0);
    step(1, 8'hDD, 0, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'hEE, 0, 0);
    check("flush_pend_ready", WW'(last_rdy), '0);
    step(0, 8'h00, 1, 0);
    check("flush_pend_data", out_data, 32'h0000DDCC);
    check("flush_pend_be", WW'(out_be), WW'(4'b0011));
    step(0, 8'h00, 1, 0);
    // Flush with nothing accumulated
    step(0, 8'h00, 1, 1);
    check("flush_empty", WW'(out_valid), '0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
